// File: rtl/seg_display.sv
// seg_display: 4-digit multiplexed 7-segment driver with per-frame input snapshot, error blink and leading-zero blanking
module seg_display #(
  parameter int REFRESH_BITS = 18,
  parameter int BLINK_BITS = 25,
  parameter bit LZB = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        empty,
  input  logic        error,
  input  logic        hi_half,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);
  localparam logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [REFRESH_BITS-1:0] ref_cnt;
  logic [BLINK_BITS-1:0] blink_cnt;
  logic [15:0] sh_value, rest;
  logic sh_empty, sh_error, sh_hi;
  logic [1:0] d;
  logic guard, blank, normal;
  logic [6:0] code;
  always_comb begin
    d = ref_cnt[REFRESH_BITS-1 -: 2];
    guard = ref_cnt[REFRESH_BITS-3 -: 4] == '0;
    rest = sh_value >> {d, 2'b00};
    normal = !sh_error && !sh_empty;
    code = sh_error ? (d == 2'd3 ? 7'h06 : 7'h2F) : sh_empty ? 7'h3F : FONT[rest[3:0]];
    blank = guard || (sh_error ? (d == 2'd0 || blink_cnt[BLINK_BITS-1])
                               : normal && LZB && d != 2'd0 && rest == '0);
  end
  // shadow registers reload only at the frame boundary so a frame never tears
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt <= '0;
      blink_cnt <= '0;
      sh_value <= '0;
      sh_empty <= 1'b1;
      sh_error <= 1'b0;
      sh_hi <= 1'b0;
      an <= 4'hF;
      seg <= 7'h7F;
      dp <= 1'b1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
      blink_cnt <= blink_cnt + 1'b1;
      if (&ref_cnt) begin
        sh_value <= value;
        sh_empty <= empty;
        sh_error <= error;
        sh_hi <= hi_half;
      end
      an <= blank ? 4'hF : ~(4'b0001 << d);
      seg <= blank ? 7'h7F : code;
      dp <= !(!blank && d == 2'd3 && normal && sh_hi);
    end
  end
endmodule

// File: tb/tb_seg_display.sv
// tb_seg_display: directed checks of scan, snapshot, modes and reset for seg_display
module tb_seg_display;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] value = '0;
  logic empty = 1'b0, error = 1'b0, hi_half = 1'b0;
  logic [3:0] an, an0;
  logic [6:0] seg, seg0;
  logic dp, dp0;
  int errors = 0, checks = 0, k = 0, mm = 0;
  logic [11:0] rec [256];

  seg_display #(.REFRESH_BITS(8), .BLINK_BITS(10), .LZB(1'b1)) dut (
    .clk(clk), .rst(rst), .value(value), .empty(empty), .error(error), .hi_half(hi_half),
    .an(an), .seg(seg), .dp(dp));
  seg_display #(.REFRESH_BITS(8), .BLINK_BITS(10), .LZB(1'b0)) dut0 (
    .clk(clk), .rst(rst), .value(value), .empty(empty), .error(error), .hi_half(hi_half),
    .an(an0), .seg(seg0), .dp(dp0));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // k counts edges since reset release; outputs sampled then reflect scan position p = k-1
  task automatic adv_to(input int p);
    while (k < p + 1) begin
      @(posedge clk);
      k++;
    end
    #2;
  endtask

  task automatic chk(input string tag, input logic [3:0] g_an, input logic [6:0] g_seg, input logic g_dp,
                     input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dp);
    checks++;
    assert ({g_an, g_seg, g_dp} === {e_an, e_seg, e_dp}) else begin
      errors++;
      $error("FAIL %s: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b", tag, g_an, g_seg, g_dp, e_an, e_seg, e_dp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("reset_hold", an, seg, dp, 4'hF, 7'h7F, 1'b1);
    chk("reset_hold_lzb0", an0, seg0, dp0, 4'hF, 7'h7F, 1'b1);
    rst = 1'b0;
    k = 0;
    adv_to(1);
    chk("guard_s0", an, seg, dp, 4'hF, 7'h7F, 1'b1);
    adv_to(36);
    chk("pre_reset_s0", an, seg, dp, 4'b1110, 7'h3F, 1'b1);
    rst = 1'b1;
    #1;
    chk("async_reset", an, seg, dp, 4'hF, 7'h7F, 1'b1);
    chk("async_reset_lzb0", an0, seg0, dp0, 4'hF, 7'h7F, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    k = 0;
    // frame 0: reset shadow is empty
    adv_to(36);
    chk("f0_s0", an, seg, dp, 4'b1110, 7'h3F, 1'b1);
    value = 16'h12AF;
    hi_half = 1'b1;
    adv_to(100);
    chk("f0_s1", an, seg, dp, 4'b1101, 7'h3F, 1'b1);
    adv_to(164);
    chk("f0_s2", an, seg, dp, 4'b1011, 7'h3F, 1'b1);
    adv_to(228);
    chk("f0_s3", an, seg, dp, 4'b0111, 7'h3F, 1'b1);
    // frame 1: 0x12AF with hi_half
    adv_to(292);
    chk("f1_s0", an, seg, dp, 4'b1110, 7'h0E, 1'b1);
    adv_to(320);
    chk("f1_s1_guard_first", an, seg, dp, 4'hF, 7'h7F, 1'b1);
    adv_to(323);
    chk("f1_s1_guard_last", an, seg, dp, 4'hF, 7'h7F, 1'b1);
    adv_to(324);
    chk("f1_s1_after_guard", an, seg, dp, 4'b1101, 7'h08, 1'b1);
    adv_to(420);
    chk("f1_s2", an, seg, dp, 4'b1011, 7'h24, 1'b1);
    adv_to(448);
    chk("f1_s3_guard", an, seg, dp, 4'hF, 7'h7F, 1'b1);
    adv_to(484);
    chk("f1_s3_dp", an, seg, dp, 4'b0111, 7'h79, 1'b0);
    value = 16'h0005;
    hi_half = 1'b0;
    // frame 2: leading-zero blanking vs always-on
    adv_to(548);
    chk("lzb_s0", an, seg, dp, 4'b1110, 7'h12, 1'b1);
    chk("nolzb_s0", an0, seg0, dp0, 4'b1110, 7'h12, 1'b1);
    adv_to(612);
    chk("lzb_s1", an, seg, dp, 4'hF, 7'h7F, 1'b1);
    chk("nolzb_s1", an0, seg0, dp0, 4'b1101, 7'h40, 1'b1);
    adv_to(676);
    chk("lzb_s2", an, seg, dp, 4'hF, 7'h7F, 1'b1);
    chk("nolzb_s2", an0, seg0, dp0, 4'b1011, 7'h40, 1'b1);
    adv_to(740);
    chk("lzb_s3", an, seg, dp, 4'hF, 7'h7F, 1'b1);
    chk("nolzb_s3", an0, seg0, dp0, 4'b0111, 7'h40, 1'b1);
    empty = 1'b1;
    error = 1'b1;
    hi_half = 1'b1;
    // frame 3: error with blink MSB high -> dark
    adv_to(804);
    chk("err_blink_s0", an, seg, dp, 4'hF, 7'h7F, 1'b1);
    adv_to(996);
    chk("err_blink_s3", an, seg, dp, 4'hF, 7'h7F, 1'b1);
    // frame 4: error visible
    adv_to(1060);
    chk("err_s0_dark", an, seg, dp, 4'hF, 7'h7F, 1'b1);
    adv_to(1124);
    chk("err_s1", an, seg, dp, 4'b1101, 7'h2F, 1'b1);
    adv_to(1188);
    chk("err_s2", an0, seg0, dp0, 4'b1011, 7'h2F, 1'b1);
    adv_to(1252);
    chk("err_s3", an, seg, dp, 4'b0111, 7'h06, 1'b1);
    error = 1'b0;
    adv_to(1316);
    chk("clr_err_s0", an, seg, dp, 4'b1110, 7'h3F, 1'b1);
    adv_to(1508);
    chk("clr_err_s3", an, seg, dp, 4'b0111, 7'h3F, 1'b1);
    empty = 1'b0;
    value = 16'h1111;
    // frame 6: change mid-frame must not tear
    adv_to(1572);
    chk("tear_s0", an, seg, dp, 4'b1110, 7'h79, 1'b1);
    adv_to(1636);
    chk("tear_s1", an, seg, dp, 4'b1101, 7'h79, 1'b1);
    value = 16'h2222;
    adv_to(1700);
    chk("tear_s2", an, seg, dp, 4'b1011, 7'h79, 1'b1);
    adv_to(1764);
    chk("tear_s3", an, seg, dp, 4'b0111, 7'h79, 1'b0);
    adv_to(1828);
    chk("next_s0", an, seg, dp, 4'b1110, 7'h24, 1'b1);
    adv_to(1892);
    chk("next_s1", an, seg, dp, 4'b1101, 7'h24, 1'b1);
    adv_to(1956);
    chk("next_s2", an, seg, dp, 4'b1011, 7'h24, 1'b1);
    adv_to(2020);
    chk("next_s3", an, seg, dp, 4'b0111, 7'h24, 1'b0);
    // frames 8..10: identical sequence each frame
    for (int j = 0; j < 256; j++) begin
      adv_to(2048 + j);
      rec[j] = {an, seg, dp};
    end
    chk("wrap_f8_s0", rec[36][11:8], rec[36][7:1], rec[36][0], 4'b1110, 7'h24, 1'b1);
    chk("wrap_f8_guard", rec[64][11:8], rec[64][7:1], rec[64][0], 4'hF, 7'h7F, 1'b1);
    chk("wrap_f8_s3", rec[228][11:8], rec[228][7:1], rec[228][0], 4'b0111, 7'h24, 1'b0);
    for (int f = 1; f < 3; f++) begin
      mm = 0;
      for (int j = 0; j < 256; j++) begin
        adv_to(2048 + 256 * f + j);
        if ({an, seg, dp} !== rec[j]) mm++;
        if (f == 2 && j == 250) value = 16'h3333;
      end
      chk_int(f == 1 ? "wrap_f9_diffs" : "wrap_f10_diffs", mm, 0);
    end
    adv_to(2817);
    value = 16'h4444;
    adv_to(2852);
    chk("snap_late_s0", an, seg, dp, 4'b1110, 7'h30, 1'b1);
    adv_to(3044);
    chk("snap_once_s3", an, seg, dp, 4'b0111, 7'h30, 1'b0);
    adv_to(3108);
    chk("snap_next_s0", an, seg, dp, 4'b1110, 7'h19, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
